alb_mp_ctrl: RTL
================

Name: alb_mp_ctrl

Overview:
Multi-precision operation controller that drives the ALB from its operand side. It takes NBYTES-wide operands and an ALB_MI op code, then issues them to the ALB one byte per step, least-significant byte first. For arithmetic ops it chains each byte's CO into the next byte's CI, collects the F bytes into a full-width result, and reports final flags with a done pulse. It sits between the microsequencer and the ALB.

Parameters:
NBYTES, 2, operand/result width in bytes (≥1).
ALB_LAT, 1, ALB clocks from inputs sampled to F/CO/VO valid (≥1).

Ports:
clk  in  1  system clock, rising edge.
resetb  in  1  synchronous reset, active-high.
start  in  1  begin operation; sampled only in IDLE.
op  in  2  ALB_MI code: 00 R-S-1+CI, 01 AND, 10 R+S+CI, 11 OR.
a_in  in  8*NBYTES  R operand.
b_in  in  8*NBYTES  S operand.
carry_in  in  1  CI for byte 0, arithmetic ops only.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse; result and flags valid.
result  out  8*NBYTES  assembled F bytes.
c_flag, z_flag, n_flag, v_flag  out  1 each  final flags.
R_out  out  8  byte to ALB R_in.
S_out  out  8  byte to ALB S_in.
CI_out  out  1  to ALB CI_in.
ALB_MI  out  2  to ALB ALB_MI.
F_in  in  8  ALB F.
CO_in, ZO_in, NO_in, VO_in  in  1 each  ALB flags; ZO_in and NO_in are unused.

Behaviour:
- Reset (resetb=1 at an edge): state IDLE. All outputs become 0, including result and flags. An in-flight operation is abandoned and no done is produced.
- States are IDLE, DRIVE, WAIT, DONE. A byte index k counts 0..NBYTES-1. A wait counter counts 0..ALB_LAT-1.
- IDLE: if start=1, latch a_in, b_in, op and carry_in. Set k=0, set chain carry = carry_in (forced to 0 for op 01/11), then go to DRIVE.
- DRIVE (1 cycle): R_out=a[8k+7:8k], S_out=b[8k+7:8k], CI_out=chain carry, ALB_MI=op. Then go to WAIT.
- WAIT (ALB_LAT cycles): hold R_out, S_out, CI_out and ALB_MI stable.
  - At the edge ending the last WAIT cycle, capture F_in into result[8k+7:8k].
  - For arithmetic ops, chain carry <= CO_in. For logic ops it stays 0.
  - At k=NBYTES-1, capture CO_in and VO_in as final c/v and go to DONE. Otherwise k++ and go to DRIVE.
- DONE (1 cycle): done=1, busy=0. Then go to IDLE.
- busy=1 in DRIVE and WAIT only. Between operations, R_out, S_out, CI_out and ALB_MI hold their last driven values.
- Latency: done is high in cycle NBYTES*(ALB_LAT+1)+1 counted after the start-sampling edge. With the defaults that is cycle 5.
- Flags, updated on entry to DONE:
  - c_flag = final CO for op 00/10, 0 for 01/11.
  - v_flag = final VO for op 00/10, 0 for 01/11.
  - n_flag = result[8*NBYTES-1].
  - z_flag = 1 iff all result bits are 0. This is computed locally, not from ZO_in.
- result and the flags hold until the next accepted start, where they are cleared to 0.
- start outside IDLE is ignored, with no queuing. start in DONE is also ignored. The earliest new start is the first IDLE cycle.
- Subtract uses ALB semantics: carry_in=1 means no borrow in. The borrow chains through CO naturally. Sub with equal operands and carry_in=1 gives 0 with C=1.
- NBYTES=1 degenerates to a single DRIVE/WAIT pass.
- A simultaneous start and resetb: reset wins.

Test Plan:
Defaults (NBYTES=2, ALB_LAT=1) with a behavioural ALB (1-cycle registered) unless stated.
1. op=10, a=00FF, b=0001, ci=0 -> ALB sees (FF,01,CI=0) then (00,00,CI=1); result=0100, C=0 Z=0 N=0 V=0; done in cycle 5.
2. op=00, a=1234, b=1234, ci=1 -> result=0000, Z=1, C=1, N=0, V=0.
3. op=10, a=FFFF, b=0001, ci=0 -> result=0000, C=1, Z=1; op=10, a=7FFF, b=0001 -> result=8000, N=1, V=1, C=0.
4. op=01, a=F0F0, b=0FF0, ci=1 -> CI_out=0 on both bytes, result=00F0, C=0, V=0; op=11, same operands -> FFF0, N=1.
5. start held high for 8 cycles -> exactly one done pulse in cycle 5 and a second operation accepted in cycle 6 (IDLE), done in cycle 11; busy never high in the same cycle as done.
6. resetb=1 in cycle 3 of an add -> next cycle busy=0, result=0, flags=0, no done pulse; start 2 cycles after reset completes a fresh op normally. Also repeat scenario 1 with ALB_LAT=3 -> done in cycle 9 and inputs held stable through WAIT.

Source files
------------

// File: rtl/alb_mp_ctrl_if.sv
// alb_mp_ctrl_if: bundles the host-side operation signals and the byte-wide ALB bus.
// master: controller view (drives busy/done/result/flags and R_out/S_out/CI_out/ALB_MI).
// slave:  environment view (drives start/op/operands/carry_in and the ALB F/CO/ZO/NO/VO returns).
interface alb_mp_ctrl_if #(parameter int NBYTES = 2);
  logic                  start;
  logic [1:0]            op;
  logic [8*NBYTES-1:0]   a_in;
  logic [8*NBYTES-1:0]   b_in;
  logic                  carry_in;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  c_flag;
  logic                  z_flag;
  logic                  n_flag;
  logic                  v_flag;
  logic [7:0]            R_out;
  logic [7:0]            S_out;
  logic                  CI_out;
  logic [1:0]            ALB_MI;
  logic [7:0]            F_in;
  logic                  CO_in;
  logic                  ZO_in;
  logic                  NO_in;
  logic                  VO_in;
  modport master (
    input  start, op, a_in, b_in, carry_in, F_in, CO_in, ZO_in, NO_in, VO_in,
    output busy, done, result, c_flag, z_flag, n_flag, v_flag, R_out, S_out, CI_out, ALB_MI
  );
  modport slave (
    output start, op, a_in, b_in, carry_in, F_in, CO_in, ZO_in, NO_in, VO_in,
    input  busy, done, result, c_flag, z_flag, n_flag, v_flag, R_out, S_out, CI_out, ALB_MI
  );
endinterface

// File: rtl/alb_mp_ctrl.sv
// alb_mp_ctrl: issues NBYTES-wide operations to the ALB one byte at a time, LSB first,
// chaining CO into CI for arithmetic ops and assembling F bytes into a full-width result.
// Ports: clk, resetb (sync, active-high), bus (alb_mp_ctrl_if.master: host op/handshake + ALB byte bus).
module alb_mp_ctrl #(
  parameter int NBYTES  = 2,
  parameter int ALB_LAT = 1
) (
  input logic           clk,
  input logic           resetb,
  alb_mp_ctrl_if.master bus
);
  localparam int KW = $clog2(NBYTES + 1);
  localparam int WW = $clog2(ALB_LAT + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;
  state_t                r_state;
  logic [8*NBYTES-1:0]   r_a;
  logic [8*NBYTES-1:0]   r_b;
  logic [8*NBYTES-1:0]   r_result;
  logic [KW-1:0]         r_k;
  logic [WW-1:0]         r_w;
  logic [7:0]            r_r;
  logic [7:0]            r_s;
  logic                  r_ci;
  logic [1:0]            r_mi;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_c;
  logic                  r_z;
  logic                  r_n;
  logic                  r_v;
  logic [8*NBYTES-1:0]   w_res;
  logic [KW-1:0]         w_kn;
  logic                  w_unused;
  assign w_kn     = r_k + 1'b1;
  assign w_unused = ^{bus.ZO_in, bus.NO_in};
  // Result as it will look once the current byte's F is captured; flags derive from this.
  always_comb begin
    w_res = r_result;
    w_res[8*r_k +: 8] = bus.F_in;
  end
  // op[0]=1 marks the logic ops (AND/OR): carry chain and C/V are forced to 0 for them.
  always_ff @(posedge clk) begin
    if (resetb) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_w      <= '0;
      r_r      <= '0;
      r_s      <= '0;
      r_ci     <= 1'b0;
      r_mi     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_a      <= bus.a_in;
          r_b      <= bus.b_in;
          r_mi     <= bus.op;
          r_k      <= '0;
          r_w      <= '0;
          r_r      <= bus.a_in[7:0];
          r_s      <= bus.b_in[7:0];
          r_ci     <= bus.carry_in & ~bus.op[0];
          r_result <= '0;
          {r_c, r_z, r_n, r_v} <= '0;
          r_busy   <= 1'b1;
          r_state  <= DRIVE;
        end
        DRIVE: r_state <= WAIT;
        WAIT: if (r_w == WW'(ALB_LAT - 1)) begin
          r_w      <= '0;
          r_result <= w_res;
          if (r_k == KW'(NBYTES - 1)) begin
            r_c     <= ~r_mi[0] & bus.CO_in;
            r_v     <= ~r_mi[0] & bus.VO_in;
            r_n     <= w_res[8*NBYTES-1];
            r_z     <= ~|w_res;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // Next byte is registered here so it is already on the bus throughout DRIVE.
            r_k     <= w_kn;
            r_r     <= r_a[8*w_kn +: 8];
            r_s     <= r_b[8*w_kn +: 8];
            r_ci    <= ~r_mi[0] & bus.CO_in;
            r_state <= DRIVE;
          end
        end else r_w <= r_w + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.c_flag = r_c;
  assign bus.z_flag = r_z;
  assign bus.n_flag = r_n;
  assign bus.v_flag = r_v;
  assign bus.R_out  = r_r;
  assign bus.S_out  = r_s;
  assign bus.CI_out = r_ci;
  assign bus.ALB_MI = r_mi;
endmodule
